gray_frame_ctrl: RTL and testbench

GRAY_FRAME_CTRL -- requirements
Module: gray_frame_ctrl

---
 rtl/gray_pkg.sv | 33 +++
 rtl/vga_timing_gen.sv | 72 +++++++
 rtl/gray_frame_ctrl.sv | 81 ++++++++
 tb/tb_gray_frame_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and VGA 640x480@60 blanking constants for the gray frame controller.
// Totals are derived from the active size so reduced geometries share one formula.
package gray_pkg;

    typedef enum logic [1:0] {
        MODE_RGB   = 2'd0,
        MODE_WGRAY = 2'd1,
        MODE_AVG   = 2'd2,
        MODE_BIN   = 2'd3
    } mode_e;

    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_ACTIVE_STD = 640;
    localparam int V_ACTIVE_STD = 480;

    function automatic int h_total_of(input int h_active);
        return h_active + H_FP + H_SYNC + H_BP;
    endfunction

    function automatic int v_total_of(input int v_active);
        return v_active + V_FP + V_SYNC + V_BP;
    endfunction

    localparam int H_TOTAL = H_ACTIVE_STD + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE_STD + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with registered sync/active decode; outputs lag the counters by 1 cycle.
// frame_start_next is the unregistered (0,0) decode so the parent can act on the same edge.
module vga_timing_gen
    import gray_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_req,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start,
    output logic       frame_start_next
);

    localparam logic [9:0] H_LAST = 10'(h_total_of(H_ACTIVE) - 1);
    localparam logic [9:0] V_LAST = 10'(v_total_of(V_ACTIVE) - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hs_n;
    logic       vs_n;

    always_comb begin
        active           = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n             = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_n             = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        frame_start_next = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_n;
            vsync       <= vs_n;
            pix_req     <= active;
            pix_x       <= active ? h_cnt : 10'd0;
            pix_y       <= active ? v_cnt : 10'd0;
            frame_start <= frame_start_next;
        end
    end

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame controller: VGA timing plus a mode shadow register that only updates on frame_start.
// One request in flight; ready stays low until the cycle after the mode lands. Option: FRAME_CNT_EN.
module gray_frame_ctrl
    import gray_pkg::*;
#(
    parameter int         H_ACTIVE = 640,
    parameter int         V_ACTIVE = 480,
    parameter logic [1:0] MODE_RST = 2'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_req_valid,
    input  logic [1:0]  mode_req_data,
    output logic        mode_req_ready,
    output logic [1:0]  mode_active,
    output logic        hsync,
    output logic        vsync,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    logic  fs_next;
    logic  pend_vld;
    logic  applied;
    logic  xfer;
    mode_e pend_mode;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk              (clk),
        .rst              (rst),
        .hsync            (hsync),
        .vsync            (vsync),
        .pix_req          (pix_req),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .frame_start      (frame_start),
        .frame_start_next (fs_next)
    );

    // applied holds ready low for the frame_start cycle itself
    assign mode_req_ready = !(pend_vld || applied);
    assign xfer           = mode_req_valid && mode_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_mode   <= MODE_RGB;
            pend_vld    <= 1'b0;
            applied     <= 1'b0;
            mode_active <= MODE_RST;
        end else begin
            applied <= fs_next && pend_vld;
            if (fs_next && pend_vld) begin
                mode_active <= pend_mode;
                pend_vld    <= 1'b0;
            end else if (xfer) begin
                pend_mode <= mode_e'(mode_req_data);
                pend_vld  <= 1'b1;
            end
        end
    end

`ifdef FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (fs_next) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Bench for gray_frame_ctrl on a reduced 8x4 active raster (same blanking) to keep frames short.
// Expected values come from raster arithmetic on the edge count and a transaction-level mode model.
module tb_gray_frame_ctrl;

    localparam int H_A = 8;
    localparam int V_A = 4;
    localparam int HT  = H_A + 16 + 96 + 48;
    localparam int VT  = V_A + 10 + 2 + 33;
    localparam int FR  = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_req_valid = 1'b0;
    logic [1:0] mode_req_data = 2'd0;
    logic       mode_req_ready;
    logic [1:0] mode_active;
    logic       hsync, vsync, pix_req, frame_start;
    logic [9:0] pix_x, pix_y;
`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    gray_frame_ctrl #(
        .H_ACTIVE (H_A),
        .V_ACTIVE (V_A),
        .MODE_RST (2'd1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mode_req_valid (mode_req_valid),
        .mode_req_data  (mode_req_data),
        .mode_req_ready (mode_req_ready),
        .mode_active    (mode_active),
        .hsync          (hsync),
        .vsync          (vsync),
        .pix_req        (pix_req),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .frame_start    (frame_start)
`ifdef FRAME_CNT_EN
        ,
        .frame_cnt      (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // k = rising edges since reset release; after edge k the outputs describe raster position k-1
    int         k;
    logic [1:0] m_active;
    logic [1:0] m_pend;
    bit         m_has_pend;
    bit         m_waiting;

    bit         e_hs, e_vs, e_pr, e_fs;
    logic [9:0] e_px, e_py;

    task automatic model_reset();
        k          = 0;
        m_active   = 2'd1;
        m_pend     = 2'd0;
        m_has_pend = 1'b0;
        m_waiting  = 1'b0;
    endtask

    function automatic bit m_rdy();
        return !m_has_pend && !m_waiting;
    endfunction

    task automatic tick();
        int pos_dec;
        bit fs_now;
        bit xfer;
        pos_dec = k % FR;
        fs_now  = (k >= 1) && (((k - 1) % FR) == 0);
        xfer    = mode_req_valid && m_rdy();
        if (fs_now) m_waiting = 1'b0;
        if (pos_dec == 0 && m_has_pend) begin
            m_active   = m_pend;
            m_has_pend = 1'b0;
            m_waiting  = 1'b1;
        end
        if (xfer) begin
            m_pend     = mode_req_data;
            m_has_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic calc_expected();
        int pos, x, y;
        pos  = (k - 1) % FR;
        x    = pos % HT;
        y    = pos / HT;
        e_hs = !(x >= H_A + 16 && x < H_A + 16 + 96);
        e_vs = !(y >= V_A + 10 && y < V_A + 12);
        e_pr = (x < H_A) && (y < V_A);
        e_px = e_pr ? 10'(x) : 10'd0;
        e_py = e_pr ? 10'(y) : 10'd0;
        e_fs = (pos == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (hsync !== 1'b1) begin mismatched++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        compared++; if (vsync !== 1'b1) begin mismatched++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        compared++; if (pix_req !== 1'b0) begin mismatched++; $display("FAIL reset_pix_req: got %b want 0", pix_req); end
        compared++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin mismatched++; $display("FAIL reset_pix_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y); end
        compared++; if (frame_start !== 1'b0) begin mismatched++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        compared++; if (mode_active !== 2'd1) begin mismatched++; $display("FAIL reset_mode_active: got %0d want 1", mode_active); end
        compared++; if (mode_req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", mode_req_ready); end
`ifdef FRAME_CNT_EN
        compared++; if (frame_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
`endif
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_timing();
        int hs_low = 0, vs_low = 0, pix_cnt = 0, hs_run = 0, last_fs = -1, fs_seen = 0;
        int fx = -1, fy = -1, lx = -1, ly = -1;
        mode_req_valid = 1'b0;
        for (int c = 0; c < 2 * FR + 1; c++) begin
            tick();
            calc_expected();
            compared++;
            if ({hsync, vsync, pix_req, frame_start} !== {e_hs, e_vs, e_pr, e_fs} || pix_x !== e_px || pix_y !== e_py) begin
                mismatched++;
                if (mismatched < 20)
                    $display("FAIL timing k=%0d: got hs=%b vs=%b req=%b fs=%b x=%0d y=%0d want hs=%b vs=%b req=%b fs=%b x=%0d y=%0d",
                             k, hsync, vsync, pix_req, frame_start, pix_x, pix_y, e_hs, e_vs, e_pr, e_fs, e_px, e_py);
            end
            compared++;
            if (mode_active !== 2'd1 || mode_req_ready !== 1'b1) begin
                mismatched++;
                if (mismatched < 20) $display("FAIL idle_mode k=%0d: got mode=%0d rdy=%b want mode=1 rdy=1", k, mode_active, mode_req_ready);
            end
            if (c < FR) begin
                if (!hsync) hs_low++;
                if (!vsync) vs_low++;
                if (pix_req) begin
                    pix_cnt++;
                    if (fx < 0) begin fx = pix_x; fy = pix_y; end
                    lx = pix_x; ly = pix_y;
                end
            end
            if (!hsync) hs_run++;
            else if (hs_run != 0) begin
                compared++;
                if (hs_run != 96) begin mismatched++; $display("FAIL hsync_line_width: got %0d want 96", hs_run); end
                hs_run = 0;
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    compared++;
                    if (k - last_fs != FR) begin mismatched++; $display("FAIL frame_period: got %0d want %0d", k - last_fs, FR); end
                end
                last_fs = k;
                fs_seen++;
            end
        end
        compared++; if (fs_seen != 3) begin mismatched++; $display("FAIL frame_start_count: got %0d want 3", fs_seen); end
        compared++; if (hs_low != 96 * VT) begin mismatched++; $display("FAIL hsync_low_frame: got %0d want %0d", hs_low, 96 * VT); end
        compared++; if (vs_low != 2 * HT) begin mismatched++; $display("FAIL vsync_low_frame: got %0d want %0d", vs_low, 2 * HT); end
        compared++; if (pix_cnt != H_A * V_A) begin mismatched++; $display("FAIL pix_count: got %0d want %0d", pix_cnt, H_A * V_A); end
        compared++; if (fx != 0 || fy != 0) begin mismatched++; $display("FAIL first_pix: got (%0d,%0d) want (0,0)", fx, fy); end
        compared++; if (lx != H_A - 1 || ly != V_A - 1) begin mismatched++; $display("FAIL last_pix: got (%0d,%0d) want (%0d,%0d)", lx, ly, H_A - 1, V_A - 1); end
`ifdef FRAME_CNT_EN
        compared++; if (frame_cnt !== 16'd3) begin mismatched++; $display("FAIL frame_cnt: got %0d want 3", frame_cnt); end
`endif
    endtask

    task automatic test_mid_frame();
        while (((k - 1) % FR) != 2 * HT) tick();
        mode_req_valid = 1'b1;
        mode_req_data  = 2'd3;
        tick();
        mode_req_valid = 1'b0;
        mode_req_data  = 2'($urandom_range(0, 3));
        compared++; if (mode_req_ready !== 1'b0) begin mismatched++; $display("FAIL mid_ready_drop: got %b want 0", mode_req_ready); end
        do begin
            tick();
            if (((k - 1) % FR) != 0) begin
                compared++;
                if (mode_active !== 2'd1 || mode_req_ready !== 1'b0) begin
                    mismatched++;
                    if (mismatched < 20) $display("FAIL mid_hold k=%0d: got mode=%0d rdy=%b want mode=1 rdy=0", k, mode_active, mode_req_ready);
                end
            end
        end while (((k - 1) % FR) != 0);
        compared++;
        if (frame_start !== 1'b1 || mode_active !== 2'd3 || mode_req_ready !== 1'b0) begin
            mismatched++; $display("FAIL mid_apply: got fs=%b mode=%0d rdy=%b want fs=1 mode=3 rdy=0", frame_start, mode_active, mode_req_ready);
        end
        tick();
        compared++; if (mode_req_ready !== 1'b1 || mode_active !== 2'd3) begin mismatched++; $display("FAIL mid_ready_return: got rdy=%b mode=%0d want rdy=1 mode=3", mode_req_ready, mode_active); end
    endtask

    task automatic test_frame_start_req();
        while (((k - 1) % FR) != 0) tick();
        compared++; if (frame_start !== 1'b1 || mode_req_ready !== 1'b1) begin mismatched++; $display("FAIL fsreq_entry: got fs=%b rdy=%b want fs=1 rdy=1", frame_start, mode_req_ready); end
        mode_req_valid = 1'b1;
        mode_req_data  = 2'd2;
        tick();
        mode_req_valid = 1'b0;
        compared++; if (mode_active !== 2'd3 || mode_req_ready !== 1'b0) begin mismatched++; $display("FAIL fsreq_same_frame: got mode=%0d rdy=%b want mode=3 rdy=0", mode_active, mode_req_ready); end
        while (((k - 1) % FR) != 0) begin
            tick();
            if (((k - 1) % FR) != 0) begin
                compared++;
                if (mode_active !== 2'd3) begin mismatched++; if (mismatched < 20) $display("FAIL fsreq_hold k=%0d: got %0d want 3", k, mode_active); end
            end
        end
        compared++; if (mode_active !== 2'd2) begin mismatched++; $display("FAIL fsreq_apply: got %0d want 2", mode_active); end
        tick();
        compared++; if (mode_req_ready !== 1'b1) begin mismatched++; $display("FAIL fsreq_ready_return: got %b want 1", mode_req_ready); end
    endtask

    task automatic test_hold_valid();
        mode_req_valid = 1'b1;
        mode_req_data  = 2'd0;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) mode_req_data = 2'd2;
            tick();
            compared++;
            if (mode_req_ready !== 1'b0 || mode_active !== 2'd2) begin
                mismatched++; $display("FAIL hold_valid i=%0d: got rdy=%b mode=%0d want rdy=0 mode=2", i, mode_req_ready, mode_active);
            end
        end
        mode_req_valid = 1'b0;
        while (((k - 1) % FR) != 0) tick();
        compared++; if (mode_active !== 2'd0) begin mismatched++; $display("FAIL hold_valid_apply: got %0d want 0", mode_active); end
    endtask

    task automatic test_random();
        for (int i = 0; i < FR + FR / 4; i++) begin
            mode_req_valid = ($urandom_range(0, 7) == 0);
            mode_req_data  = 2'($urandom_range(0, 3));
            tick();
            compared++;
            if (mode_active !== m_active || mode_req_ready !== m_rdy()) begin
                mismatched++;
                if (mismatched < 20) $display("FAIL random k=%0d: got mode=%0d rdy=%b want mode=%0d rdy=%b", k, mode_active, mode_req_ready, m_active, m_rdy());
            end
        end
        mode_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        while (!m_rdy() && guard < 2 * FR) begin tick(); guard++; end
        compared++; if (mode_req_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_ready_wait: got %b want 1", mode_req_ready); end
        while (((k - 1) % FR) != 3 * HT) tick();
        mode_req_valid = 1'b1;
        mode_req_data  = 2'd0;
        tick();
        mode_req_valid = 1'b0;
        compared++; if (mode_req_ready !== 1'b0) begin mismatched++; $display("FAIL rstmid_pending: got rdy=%b want 0", mode_req_ready); end
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({hsync, vsync, pix_req, frame_start} !== 4'b1100 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            mismatched++; $display("FAIL rstmid_outputs: got hs=%b vs=%b req=%b fs=%b x=%0d y=%0d want 1,1,0,0,0,0", hsync, vsync, pix_req, frame_start, pix_x, pix_y);
        end
        compared++; if (mode_active !== 2'd1 || mode_req_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_mode: got mode=%0d rdy=%b want mode=1 rdy=1", mode_active, mode_req_ready); end
`ifdef FRAME_CNT_EN
        compared++; if (frame_cnt !== 16'd0) begin mismatched++; $display("FAIL rstmid_frame_cnt: got %0d want 0", frame_cnt); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        compared++;
        if (frame_start !== 1'b1 || pix_req !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            mismatched++; $display("FAIL rstmid_first_frame: got fs=%b req=%b x=%0d y=%0d want 1,1,0,0", frame_start, pix_req, pix_x, pix_y);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if (mode_active !== 2'd1 || mode_req_ready !== 1'b1) begin
                mismatched++; $display("FAIL rstmid_discard i=%0d: got mode=%0d rdy=%b want mode=1 rdy=1", i, mode_active, mode_req_ready);
            end
        end
    endtask

    initial begin
        #(10 * 12 * FR);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_timing();
        test_mid_frame();
        test_frame_start_req();
        test_hold_valid();
        test_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
